// File: rtl/intt_arbiter.sv
// Round-robin front end that time-shares one intt engine between NREQ polynomial producers.
// A grant lasts one polynomial: N coefficients in, then N results routed back to the winner.
//
// state | meaning
// IDLE  | no grant held; one arbitration cycle when any req_valid is high
// LOAD  | granted requester streams its N coefficients into the engine
// DRAIN | engine computes, then its N results return to the granted requester
module intt_arbiter #(
    parameter int Q    = 17,
    parameter int N    = 8,
    parameter int LOGQ = 5,
    parameter int LOGN = 3,
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*LOGQ-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [LOGQ-1:0]      rsp_data,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 eng_in_valid,
    output logic [LOGQ-1:0]      eng_poly_in,
    input  logic                 eng_in_ready,
    input  logic                 eng_out_valid,
    input  logic [LOGQ-1:0]      eng_poly_out,
    output logic                 eng_out_ready,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 done
);

    // Q is carried for documentation; it only has to fit the coefficient width.
    if (Q < 2 || Q > (1 << LOGQ)) begin : g_bad_q
        $error("intt_arbiter: Q does not fit in LOGQ bits");
    end
    if (N != (1 << LOGN) || NREQ < 2 || (1 << IDW) < NREQ) begin : g_bad_geom
        $error("intt_arbiter: inconsistent N/LOGN or NREQ/IDW");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [LOGN:0]   r_cnt, w_cnt_nxt;
    logic [IDW-1:0]  r_grant, w_grant_nxt;
    logic [IDW-1:0]  r_last, w_last_nxt;
    logic            r_done, w_done_nxt;
    logic [IDW-1:0]  w_pick, w_cand;
    logic            w_found;
    logic            w_in_beat, w_out_beat, w_cnt_last;
    logic [LOGQ-1:0] w_coef [NREQ];

    for (genvar r = 0; r < NREQ; r++) begin : g_coef
        assign w_coef[r] = req_data[r*LOGQ +: LOGQ];
    end

    // First requesting index after the last grant, wrapping around.
    always_comb begin
        w_pick  = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(r_last) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_in_beat  = (r_state == S_LOAD)  && eng_in_valid  && eng_in_ready;
    assign w_out_beat = (r_state == S_DRAIN) && eng_out_valid && eng_out_ready;
    assign w_cnt_last = (r_cnt == (LOGN+1)'(N - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_grant <= '0;
            r_last  <= IDW'(NREQ - 1);
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_in_beat) begin
                    if (w_cnt_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt + (LOGN+1)'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (w_out_beat) begin
                    if (w_cnt_last) begin
                        w_cnt_nxt   = '0;
                        w_last_nxt  = r_grant;
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + (LOGN+1)'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Only the granted lane ever sees handshakes; rsp_data is a plain broadcast of the engine.
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        eng_in_valid  = 1'b0;
        eng_poly_in   = '0;
        eng_out_ready = 1'b0;
        rsp_data      = eng_poly_out;
        case (r_state)
            S_LOAD: begin
                eng_in_valid       = req_valid[r_grant];
                eng_poly_in        = w_coef[r_grant];
                req_ready[r_grant] = eng_in_ready;
            end
            S_DRAIN: begin
                rsp_valid[r_grant] = eng_out_valid;
                eng_out_ready      = rsp_ready[r_grant];
            end
            default: ;
        endcase
    end

    assign busy     = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign grant_id = r_grant;
    assign done     = r_done;

endmodule

// File: doc/intt_arbiter.md
Name: intt_arbiter

Overview:
Shares one intt engine between NREQ polynomial producers. Grants the engine to one requester per polynomial, round-robin. Streams that requester's N coefficients into the engine, then routes the engine's N outputs back to the same requester. Sits between the requester streams and a single intt instance, which is driven from the same clk and reset_n.

Parameters:
q, 17, modulus; passed through for documentation only, no arithmetic here
N, 8, coefficients per polynomial
logq, 5, coefficient width
logN, 3, log2(N)
NREQ, 2, number of requesters (>=2)
IDW, 1, grant id width, equal to clog2(NREQ)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset, sampled on rising clk
req_valid  in  NREQ  per-requester input coefficient valid
req_data  in  NREQ*logq  packed coefficients; requester r uses bits [r*logq +: logq]
req_ready  out  NREQ  per-requester input ready
rsp_valid  out  NREQ  per-requester result valid
rsp_data  out  logq  result coefficient, broadcast to all requesters
rsp_ready  in  NREQ  per-requester result ready
eng_in_valid  out  1  to intt in_valid
eng_poly_in  out  logq  to intt poly_in
eng_in_ready  in  1  from intt in_ready
eng_out_valid  in  1  from intt out_valid
eng_poly_out  in  logq  from intt poly_out
eng_out_ready  out  1  to intt out_ready
busy  out  1  high in LOAD or DRAIN
grant_id  out  IDW  current or last granted requester
done  out  1  one-cycle pulse after the final result beat

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset values: state=IDLE, cnt=0, grant_id=0, last_grant=NREQ-1, done=0. All req_ready, rsp_valid, eng_in_valid, eng_out_ready and busy are 0.
- Reset mid-operation: all state is abandoned and the block is IDLE on the next cycle. The engine shares reset_n, so it also restarts in its STORE state.
- IDLE: if any req_valid bit is high, pick the first set bit searching from last_grant+1 upward with wrap. Register it into grant_id and move to LOAD. This costs one arbitration cycle with no handshake. With no req_valid, stay in IDLE.
- LOAD:
  - eng_in_valid = req_valid[grant_id]
  - eng_poly_in = the grant_id slice of req_data
  - req_ready[grant_id] = eng_in_ready; all other req_ready bits are 0
  - cnt increments on each eng_in_valid & eng_in_ready beat. On beat N, cnt returns to 0 and state moves to DRAIN.
  - If the granted requester drops valid, the arbiter waits. There is no timeout and no re-arbitration.
- DRAIN:
  - rsp_valid[grant_id] = eng_out_valid; rsp_data = eng_poly_out; eng_out_ready = rsp_ready[grant_id]
  - The engine's compute phase is simply DRAIN with eng_out_valid low.
  - cnt increments on each eng_out_valid & eng_out_ready beat. On beat N: last_grant <= grant_id, cnt <= 0, state <= IDLE, and done is 1 in the next cycle only.
- Outside the active phase all engine-side valid/ready outputs are 0. Non-granted requesters always see ready=0 and rsp_valid=0.
- Every output is combinational from registered state plus the named inputs. No path goes from req_* directly to rsp_*.
- A requester whose valid rises during another requester's polynomial is considered only at the next IDLE.
- A granted requester may raise valid for its next polynomial while in DRAIN. It is not accepted until re-granted; round-robin passes over it if others are waiting.
- cnt is logN+1 bits wide, so the count of N beats does not wrap.

Test Plan:
1. After reset, only req_valid[0] high with 8 zero coefficients -> grant_id=0; exactly 8 beats on rsp_valid[0], all rsp_data=0; req_ready[1] and rsp_valid[1] stay 0; one done pulse.
2. Both requesters continuously valid for 4 polynomials -> grant order 0,1,0,1; each IDLE dwell is exactly 1 cycle; 4 done pulses.
3. Random polynomials with q=17 checked against the golden iNTT model -> rsp_data matches per requester in order, none misrouted.
4. rsp_ready[grant_id] held low for 5 cycles mid-DRAIN -> eng_out_ready low and rsp_data stable over those cycles; still exactly 8 beats, none lost or duplicated.
5. Granted requester drops req_valid for 3 cycles after beat 3 in LOAD -> eng_in_valid low and cnt held at 3; load resumes and completes with 8 beats.
6. reset_n low for 1 cycle during DRAIN at beat 4 -> next cycle busy=0 and all valid/ready outputs 0; the next arbitration grants requester 0.
